// File: rtl/mdu_if.sv
// Bundles the EXE-stage <-> multiply/divide sequencer signals.
// master = EXE stage side, slave = the sequencer itself.
interface mdu_if;
  logic        start;
  logic [6:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] hi_cur;
  logic [31:0] lo_cur;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs, rt, hi_cur, lo_cur, flush,
    input  stall, busy, hilo_we, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, hi_cur, lo_cur, flush,
    output stall, busy, hilo_we, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EXE stage.
// Multiplies run for a fixed MUL_LAT cycles; divides use a 32-step
// restoring divider on magnitudes followed by a sign-fix cycle.
// The 64-bit result is presented for one cycle with a HILO write strobe.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  localparam logic [6:0] OP_MUL   = 7'd30;
  localparam logic [6:0] OP_MULT  = 7'd31;
  localparam logic [6:0] OP_MULTU = 7'd32;
  localparam logic [6:0] OP_DIV   = 7'd33;
  localparam logic [6:0] OP_DIVU  = 7'd34;
  localparam logic [6:0] OP_MADD  = 7'd35;
  localparam logic [6:0] OP_MADDU = 7'd36;
  localparam logic [6:0] OP_MSUB  = 7'd37;
  localparam logic [6:0] OP_MSUBU = 7'd38;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic        div_mode, sgn_mode, neg_a, neg_b;
  acc_t        acc_mode;
  logic [31:0] opa;        // multiplicand, or dividend magnitude shifting into quotient
  logic [31:0] opb;        // multiplier, or divisor magnitude
  logic [31:0] rem;
  logic [63:0] acc;
  logic [31:0] hi_q, lo_q;

  logic        is_mdu, dec_div, dec_signed, accept;
  acc_t        dec_acc;
  logic [63:0] mul_a, mul_b, prod, mul_res;
  logic [32:0] shifted, diff;
  logic [31:0] rem_next, q_fix, r_fix;

  // Decode the incoming op into class, signedness and accumulate mode.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    is_mdu     = 1'b1;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    dec_acc    = ACC_NONE;
    case (bus.op)
      OP_MULT:  dec_signed = 1'b1;
      OP_MULTU: ;
      OP_DIV:   begin dec_div = 1'b1; dec_signed = 1'b1; end
      OP_DIVU:  dec_div = 1'b1;
      OP_MADD:  begin dec_signed = 1'b1; dec_acc = ACC_ADD; end
      OP_MADDU: dec_acc = ACC_ADD;
      OP_MSUB:  begin dec_signed = 1'b1; dec_acc = ACC_SUB; end
      OP_MSUBU: dec_acc = ACC_SUB;
      default:  is_mdu = 1'b0;   // includes OP_MUL, which writes a GPR instead
    endcase
  end

  assign accept = (state == S_IDLE) && bus.start && is_mdu && !bus.flush;

  // Multiply path: operands extended to 64 bits so the low half of the
  // product is correct for both signed and unsigned forms.
  always_comb begin
    mul_a = {{32{sgn_mode & opa[31]}}, opa};
    mul_b = {{32{sgn_mode & opb[31]}}, opb};
    prod  = mul_a * mul_b;
    case (acc_mode)
      ACC_ADD: mul_res = acc + prod;
      ACC_SUB: mul_res = acc - prod;
      default: mul_res = prod;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit and
  // subtract the divisor if it fits. A zero divisor always "fits", which
  // yields the all-ones quotient and the dividend as remainder.
  always_comb begin
    shifted  = {rem, opa[31]};
    diff     = shifted - {1'b0, opb};
    rem_next = diff[32] ? shifted[31:0] : diff[31:0];
    q_fix    = (sgn_mode && (neg_a ^ neg_b)) ? -opa : opa;
    r_fix    = (sgn_mode && neg_a) ? -rem : rem;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a flush aborts any in-flight op back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = dec_div ? S_DIV : S_MUL;
      S_MUL:  if (bus.flush) state_next = S_IDLE;
              else if (cnt == 5'd0) state_next = S_DONE;
      S_DIV:  if (bus.flush) state_next = S_IDLE;
              else if (cnt == 5'd0) state_next = S_FIX;
      S_FIX:  state_next = bus.flush ? S_IDLE : S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs: stall covers the acceptance cycle and every working state.
  always_comb begin
    bus.stall   = accept || (state inside {S_MUL, S_DIV, S_FIX});
    bus.busy    = (state != S_IDLE);
    bus.hilo_we = (state == S_DONE) && !bus.flush;
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

  // Datapath: operand capture, counter, divider iteration, result load.
  // NOTE: datapath registers are reset too, so outputs and counters come
  // up at zero and a reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div_mode <= 1'b0;
      sgn_mode <= 1'b0;
      acc_mode <= ACC_NONE;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      rem      <= '0;
      acc      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          div_mode <= dec_div;
          sgn_mode <= dec_signed;
          acc_mode <= dec_acc;
          neg_a    <= bus.rs[31];
          neg_b    <= bus.rt[31];
          acc      <= {bus.hi_cur, bus.lo_cur};
          rem      <= '0;
          if (dec_div) begin
            cnt <= 5'd31;
            opa <= (dec_signed && bus.rs[31]) ? -bus.rs : bus.rs;
            opb <= (dec_signed && bus.rt[31]) ? -bus.rt : bus.rt;
          end else begin
            cnt <= 5'(MUL_LAT - 1);
            opa <= bus.rs;
            opb <= bus.rt;
          end
        end
        S_MUL: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          if (state_next == S_DONE) {hi_q, lo_q} <= mul_res;
        end
        S_DIV: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          rem <= rem_next;
          opa <= {opa[30:0], ~diff[32]};
        end
        S_FIX: if (state_next == S_DONE && div_mode) begin
          hi_q <= r_fix;
          lo_q <= q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases, flush/reset aborts,
// and randomized ops compared against a plain-arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 2;

  localparam logic [6:0] OP_ADD   = 7'd1;
  localparam logic [6:0] OP_MUL   = 7'd30;
  localparam logic [6:0] OP_MULT  = 7'd31;
  localparam logic [6:0] OP_MULTU = 7'd32;
  localparam logic [6:0] OP_DIV   = 7'd33;
  localparam logic [6:0] OP_DIVU  = 7'd34;
  localparam logic [6:0] OP_MADD  = 7'd35;
  localparam logic [6:0] OP_MADDU = 7'd36;
  localparam logic [6:0] OP_MSUB  = 7'd37;
  localparam logic [6:0] OP_MSUBU = 7'd38;

  logic clk = 1'b0;
  logic rst;
  mdu_if bus ();

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_div_op(input logic [6:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Reference result {hi, lo} computed straight from the arithmetic rules.
  function automatic logic [63:0] ref_result(input logic [6:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    logic [63:0] p;
    longint      sa, sb;
    logic [31:0] ma, mb, q, r;
    bit          sgn;
    if (is_div_op(op)) begin
      sgn = (op == OP_DIV);
      ma  = (sgn && a[31]) ? -a : a;
      mb  = (sgn && b[31]) ? -b : b;
      if (mb == 0) begin
        q = 32'hFFFF_FFFF;
        r = ma;
      end else begin
        q = ma / mb;
        r = ma % mb;
      end
      if (sgn && (a[31] != b[31])) q = -q;
      if (sgn && a[31]) r = -r;
      return {r, q};
    end
    if (op inside {OP_MULT, OP_MADD, OP_MSUB}) begin
      sa = $signed(a);
      sb = $signed(b);
      p  = 64'(sa * sb);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    if (op inside {OP_MADD, OP_MADDU}) return {h, l} + p;
    if (op inside {OP_MSUB, OP_MSUBU}) return {h, l} - p;
    return p;
  endfunction

  task automatic drive(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs     = a;
    bus.rt     = b;
    bus.hi_cur = h;
    bus.lo_cur = l;
  endtask

  // Issue one op (called #1 after a rising edge = cycle 0) and check stall
  // span, write cycle, single pulse, result and idle afterwards.
  task automatic run_op(input string tag, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
    logic [63:0] exp;
    logic [31:0] got_hi, got_lo;
    int          lat, n_stall, n_we, we_at;
    exp     = ref_result(op, a, b, h, l);
    lat     = is_div_op(op) ? 34 : MUL_LAT + 1;
    n_stall = 0;
    n_we    = 0;
    we_at   = -1;
    got_hi  = '0;
    got_lo  = '0;
    drive(op, a, b, h, l);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (bus.stall) n_stall++;
      if (bus.hilo_we) begin
        n_we++;
        if (we_at < 0) we_at = c;
        got_hi = bus.hi;
        got_lo = bus.lo;
      end
      @(posedge clk);
      #1;
      if (c == lat) bus.start = 1'b0;
    end
    @(negedge clk);
    if (bus.hilo_we) n_we++;
    check({tag, "_stall_cycles"}, 64'(n_stall), 64'(lat));
    check({tag, "_we_cycle"}, 64'(we_at), 64'(lat));
    check({tag, "_we_count"}, 64'(n_we), 64'd1);
    check({tag, "_hi"}, {32'd0, got_hi}, {32'd0, exp[63:32]});
    check({tag, "_lo"}, {32'd0, got_lo}, {32'd0, exp[31:0]});
    check({tag, "_idle_after"}, {63'd0, bus.busy}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [6:0] ops [8];
    int         n_we, bad_stall, bad_busy, bad_we, bad_hilo;
    logic [31:0] a, b;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = OP_ADD;
    bus.rs     = '0;
    bus.rt     = '0;
    bus.hi_cur = '0;
    bus.lo_cur = '0;
    bus.flush  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {63'd0, bus.stall}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_we", {63'd0, bus.hilo_we}, 64'd0);
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    run_op("div_7_0", OP_DIV, 32'd7, 32'd0, 32'd0, 32'd0);
    run_op("maddu_wrap", OP_MADDU, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("msub_wrap", OP_MSUB, 32'd1, 32'd1, 32'd0, 32'd0);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    run_op("div_neg_by0", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0);

    // Flush during a divide at cycle 10, then a MULT accepted at cycle 11
    n_we = 0;
    drive(OP_DIV, 32'd1000, 32'd3, 32'd0, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.hilo_we) n_we++;
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    if (bus.hilo_we) n_we++;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_div_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_div_stall", {63'd0, bus.stall}, 64'd0);
    check("flush_div_no_we", 64'(n_we), 64'd0);
    run_op("mult_after_flush", OP_MULT, 32'd12345, 32'hFFFF_FF00, 32'd0, 32'd0);

    // Flush coinciding with DONE suppresses the write
    drive(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd0);
    repeat (MUL_LAT + 1) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_done_we", {63'd0, bus.hilo_we}, 64'd0);
    check("flush_done_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush_done_busy", {63'd0, bus.busy}, 64'd0);

    // Reset at cycle 5 of a DIVU, with non-MDU ops held on start afterwards
    drive(OP_DIVU, 32'd5000, 32'd13, 32'd0, 32'd0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst    = 1'b1;
    bus.op = OP_MUL;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bad_stall = 0;
    bad_busy  = 0;
    bad_we    = 0;
    bad_hilo  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.stall !== 1'b0) bad_stall++;
      if (bus.busy !== 1'b0) bad_busy++;
      if (bus.hilo_we !== 1'b0) bad_we++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) bad_hilo++;
      @(posedge clk);
      #1;
      if (i == 19) bus.op = OP_ADD;
    end
    bus.start = 1'b0;
    check("rst_abort_stall", 64'(bad_stall), 64'd0);
    check("rst_abort_busy", 64'(bad_busy), 64'd0);
    check("rst_abort_we", 64'(bad_we), 64'd0);
    check("rst_abort_hilo", 64'(bad_hilo), 64'd0);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = $urandom_range(1, 20);
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rand%0d", n), ops[$urandom_range(0, 7)], a, b, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the EXE stage. It accepts HI/LO-writing arithmetic ops (MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU), runs them over a fixed-latency multiply path or a 32-iteration restoring divider, and stalls the pipeline while running. It delivers a one-cycle HILO write with the 64-bit result, and aborts cleanly on an exception flush from MEM.

## Interface
- MUL_LAT, 2, cycles spent in MUL state (legal range 1..8).
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  EXE holds a valid instruction this cycle.
- op_i  input  7  InstrType code of the EXE instruction.
- rs_i  input  32  operand A (dividend/multiplicand).
- rt_i  input  32  operand B (divisor/multiplier).
- hi_i, lo_i  input  32 each  current architectural HI/LO (forwarded), used by MADD/MSUB.
- flush_i  input  1  exception flush; kills any in-flight op.
- stall_o  output  1  hold PC and IF/ID/EXE registers.
- busy_o  output  1  state is not IDLE.
- hilo_we_o  output  1  one-cycle HILO write strobe.
- hi_o, lo_o  output  32 each  result; valid when hilo_we_o=1.

## Operation
- An op is an MDU op iff op_i is one of OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU. All other codes, including OP_MUL, never start the block.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: if start_i & MDU op & ~flush_i, latch operands, op, and {hi_i,lo_i}.
  - Multiply ops go to MUL with counter = MUL_LAT-1.
  - Divide ops go to DIV with iteration counter = 31.
- MUL: counter decrements each cycle. At 0, go to DONE.
  - Product is signed for MULT/MADD/MSUB and unsigned otherwise.
  - MADD*: result = {HI,LO} + product. MSUB*: result = {HI,LO} - product.
  - Arithmetic is 64-bit modulo 2^64, with no overflow exception.
- DIV: one restoring step per cycle on magnitudes (|rs|,|rt| for DIV; raw values for DIVU). After the step with counter=0, go to FIX.
- FIX: signed DIV only; quotient is negated if operand signs differ, and remainder takes the dividend's sign. DIVU passes values through unchanged. Then go to DONE.
- Divide by zero falls out of the algorithm: magnitude quotient = 0xFFFFFFFF, magnitude remainder = |dividend|, then FIX applies. No exception.
- Result mapping for divide ops: lo_o = quotient, hi_o = remainder.
- DONE: hilo_we_o=1 with hi_o/lo_o, stall_o=0. start_i is ignored. Next state is IDLE unconditionally.
- flush_i in MUL/DIV/FIX/DONE: next state IDLE, and hilo_we_o is forced 0 in that cycle. flush_i in IDLE blocks acceptance.
- rst in any state: IDLE next cycle, and the in-flight result is discarded.

## Timing
- Reset values: stall_o=0, busy_o=0, hilo_we_o=0, hi_o=0, lo_o=0. Internal counters are also 0.
- stall_o = (IDLE & start_i & MDU op & ~flush_i) | state∈{MUL,DIV,FIX}. It is combinational and asserted in the acceptance cycle.
- Acceptance cycle = cycle 0.
  - Multiply: DONE / hilo_we_o at cycle MUL_LAT+1 (cycle 3 with the default).
  - Divide: DIV spans cycles 1..32, FIX is cycle 33, DONE is cycle 34.
- The EXE instruction advances at the end of the DONE cycle.
  - A back-to-back MDU op is accepted no earlier than the cycle after DONE.
  - Minimum spacing is MUL_LAT+2 cycles for multiply and 35 cycles for divide.
- hi_o/lo_o are registered. They hold their last value outside DONE, but consumers use them only while hilo_we_o=1.
- Flush in the same cycle as DONE suppresses the write.
  - stall_o is 0 in that cycle.
  - busy_o is 0 the next cycle.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=5, MUL_LAT=2 -> stall_o high cycles 0–2; at cycle 3 hilo_we_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
- DIVU rs=100, rt=7 -> stall_o high cycles 0–33; at cycle 34 lo_o=14, hi_o=2, hilo_we_o=1 for exactly one cycle.
- DIV rs=-7, rt=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV rs=7, rt=0 -> lo_o=0xFFFFFFFF, hi_o=7. Both complete at cycle 34.
- MADDU hi_i=lo_i=0xFFFFFFFF, rs=rt=1 -> wrap-around gives hi_o=0, lo_o=0. MSUB hi_i=lo_i=0, rs=1, rt=1 -> hi_o=lo_o=0xFFFFFFFF.
- DIV started, flush_i=1 at cycle 10 -> state IDLE at cycle 11, stall_o=0, no hilo_we_o pulse. A new MULT accepted at cycle 11 completes at cycle 14 with correct values.
- rst pulsed at cycle 5 of a DIVU, and start_i held high with OP_MUL/OP_ADD -> all outputs at reset values, no stall, no write ever issued.
